vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/wrap_counter.sv | 26 ++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and width helper
package vga_pkg;

  // 640x480@60 is the normal build; SIM shrinks the raster so a whole frame
  // fits in a couple of hundred clocks.
`ifdef SIM
  localparam int DEF_H_ACTIVE = 8;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 2;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 4;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BP     = 1;
`else
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
`endif

  localparam int DEF_CLK_DIV = 2;

  // Bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between generator and pixel sources
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          en;
  logic          next_px;
  logic          VGA_HSYNC;
  logic          VGA_VSYNC;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en,
    output next_px, VGA_HSYNC, VGA_VSYNC, x, y, active, line_start, frame_start
  );

  modport slave (
    output en,
    input  next_px, VGA_HSYNC, VGA_VSYNC, x, y, active, line_start, frame_start
  );
endinterface

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo counter 0..MAX with wrap event and reset preset
module wrap_counter #(
  parameter int MAX  = 1,
  parameter int W    = 1,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST  = W'(MAX);
  localparam logic [W-1:0] START = W'(INIT);

  // wrap is the event of stepping past LAST, so it can directly qualify the
  // next counter in a cascade.
  assign wrap = inc && (cnt == LAST);

  // Count on inc, fold back to 0 after LAST, preset to INIT on reset.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= START;
    else if (wrap) cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = clog2(H_TOTAL);
  localparam int YW      = clog2(V_TOTAL);
  localparam int PW      = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] P_LAST   = PW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG_X = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END_X = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_ACT_Y  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG_Y = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END_Y = YW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: every active/porch/sync length must be nonzero and CLK_DIV >= 1");
  end

  logic [PW-1:0] p;
  logic [XW-1:0] h, h_n;
  logic [YW-1:0] v, v_n;
  logic          p_wrap, h_wrap, v_wrap;
  logic          active_q, hs_q, vs_q, line_start_q, frame_start_q;

  // Prescaler: its wrap event is the pixel tick that advances h.
  wrap_counter #(.MAX(CLK_DIV - 1), .W(PW), .INIT(0)) u_prescale (
    .clk  (CLK50MHZ),
    .rst  (RST),
    .inc  (vga.en),
    .cnt  (p),
    .wrap (p_wrap)
  );

  // Horizontal position; resets to the last back-porch pixel so the first
  // tick after reset lands on (0,0).
  wrap_counter #(.MAX(H_TOTAL - 1), .W(XW), .INIT(H_TOTAL - 1)) u_hcount (
    .clk  (CLK50MHZ),
    .rst  (RST),
    .inc  (p_wrap),
    .cnt  (h),
    .wrap (h_wrap)
  );

  // Vertical position, stepped once per completed line.
  wrap_counter #(.MAX(V_TOTAL - 1), .W(YW), .INIT(V_TOTAL - 1)) u_vcount (
    .clk  (CLK50MHZ),
    .rst  (RST),
    .inc  (h_wrap),
    .cnt  (v),
    .wrap (v_wrap)
  );

  assign vga.next_px = vga.en && (p == P_LAST);

  // Position the counters will hold after this edge; outputs decode from it
  // so they switch on the same edge as x/y.
  always_comb begin
    h_n = h;
    v_n = v;
    if (h_wrap)      h_n = '0;
    else if (p_wrap) h_n = h + 1'b1;
    if (v_wrap)      v_n = '0;
    else if (h_wrap) v_n = v + 1'b1;
  end

  // Registered sync/blank/strobe outputs; hold levels and kill strobes while disabled.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      active_q      <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (vga.en) begin
      active_q      <= (h_n < H_ACT_X) && (v_n < V_ACT_Y);
      hs_q          <= ((h_n >= HS_BEG_X) && (h_n < HS_END_X)) ? HS_POL : ~HS_POL;
      vs_q          <= ((v_n >= VS_BEG_Y) && (v_n < VS_END_Y)) ? VS_POL : ~VS_POL;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.x           = h;
  assign vga.y           = v;
  assign vga.active      = active_q;
  assign vga.VGA_HSYNC   = hs_q;
  assign vga.VGA_VSYNC   = vs_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
endmodule
